// File: rtl/vend_controller.sv
// vend_controller: coin filtering, product selection, dispense handshake and
// greedy change/refund payout for the vending machine coin accumulator.
// Optional feature: define VM_AUTO_REFUND_EN to build the inactivity
// auto-refund counter (TIMEOUT_CYCLES); without it COLLECT waits indefinitely.
module vend_controller #(
  parameter int unsigned PRICE0         = 5,
  parameter int unsigned PRICE1         = 8,
  parameter int unsigned PRICE2         = 12,
  parameter int unsigned PRICE3         = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [4:0] coin_value,
  output logic       coin_reject,
  output logic [4:0] acc_coin_value,
  output logic       acc_clear,
  input  logic [4:0] current_amount,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  output logic       sel_reject,
  input  logic       cancel_req,
  output logic       dispense_valid,
  output logic [1:0] dispense_id,
  input  logic       dispense_ready,
  output logic       change_valid,
  output logic [4:0] change_coin,
  input  logic       change_ready,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, COLLECT, DISPENSE, CHANGE, CLEAR} state_t;

  state_t     state, state_next;
  logic [4:0] remaining, remaining_next;
  logic [1:0] dispense_id_next;
  logic [4:0] acc_coin_next;
  logic       coin_reject_next;
  logic       sel_reject_next;
  logic       take_coin;

  logic [5:0] effective;
  logic [5:0] coin_sum;
  logic [5:0] price;
  logic [5:0] sel_diff;
  logic       coin_legal;
  logic       coin_ok;
  logic       afford;
  logic       timeout_hit;
  logic [4:0] greedy_coin;
  logic [4:0] change_left;

  if (TIMEOUT_CYCLES == 0 || PRICE0 == 0 || PRICE1 == 0 || PRICE2 == 0 || PRICE3 == 0)
  begin : g_bad_cfg
    $error("vend_controller: prices and TIMEOUT_CYCLES must be nonzero");
  end

  // Credit includes the coin still in flight to the accumulator.
  assign effective  = {1'b0, current_amount} + {1'b0, acc_coin_value};
  assign coin_sum   = effective + {1'b0, coin_value};
  assign coin_legal = (coin_value == 5'd1) || (coin_value == 5'd5) || (coin_value == 5'd10);
  assign coin_ok    = coin_legal && (coin_sum <= 6'd31);

  // Price lookup for the strobed product.
  always_comb begin
    price = '0;
    case (sel_id)
      2'd0: price = 6'(PRICE0);
      2'd1: price = 6'(PRICE1);
      2'd2: price = 6'(PRICE2);
      2'd3: price = 6'(PRICE3);
      default: price = '0;
    endcase
  end

  assign afford   = effective >= price;
  assign sel_diff = effective - price;

  // Largest denomination not exceeding what is still owed.
  always_comb begin
    greedy_coin = 5'd1;
    if (remaining >= 5'd10)     greedy_coin = 5'd10;
    else if (remaining >= 5'd5) greedy_coin = 5'd5;
  end

  assign change_left = remaining - greedy_coin;

  assign dispense_valid = (state == DISPENSE);
  assign change_valid   = (state == CHANGE);
  assign change_coin    = change_valid ? greedy_coin : '0;
  assign acc_clear      = (state == CLEAR);
  assign busy           = (state == DISPENSE) || (state == CHANGE) || (state == CLEAR);

`ifdef VM_AUTO_REFUND_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_count;

  // Inactivity counter; restarts off the registered coin/reject pulses, so
  // activity is seen one cycle late, which only shifts the timeout by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_count <= '0;
    else if (state != COLLECT || acc_coin_value != '0 || sel_reject)
      idle_count <= '0;
    else if (!timeout_hit)
      idle_count <= idle_count + TW'(1);
  end

  assign timeout_hit = (state == COLLECT) && (idle_count == TW'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and registered-output decode; cancel > selection > coin.
  always_comb begin
    state_next       = state;
    remaining_next   = remaining;
    dispense_id_next = dispense_id;
    acc_coin_next    = '0;
    coin_reject_next = coin_valid;
    sel_reject_next  = 1'b0;
    take_coin        = 1'b0;

    case (state)
      IDLE: begin
        take_coin       = coin_valid;
        sel_reject_next = sel_valid;
      end
      COLLECT: begin
        if (cancel_req || timeout_hit) begin
          remaining_next = effective[4:0];
          state_next     = (effective != '0) ? CHANGE : CLEAR;
        end else if (sel_valid && afford) begin
          dispense_id_next = sel_id;
          remaining_next   = sel_diff[4:0];
          state_next       = DISPENSE;
        end else begin
          sel_reject_next = sel_valid;
          take_coin       = coin_valid;
        end
      end
      DISPENSE: begin
        if (dispense_ready)
          state_next = (remaining != '0) ? CHANGE : CLEAR;
      end
      CHANGE: begin
        if (change_ready) begin
          remaining_next = change_left;
          if (change_left == '0)
            state_next = CLEAR;
        end
      end
      CLEAR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (take_coin) begin
      coin_reject_next = !coin_ok;
      if (coin_ok) begin
        acc_coin_next = coin_value;
        state_next    = COLLECT;
      end
    end
  end

  // State, payout balance and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      remaining      <= '0;
      dispense_id    <= '0;
      acc_coin_value <= '0;
      coin_reject    <= 1'b0;
      sel_reject     <= 1'b0;
    end else begin
      state          <= state_next;
      remaining      <= remaining_next;
      dispense_id    <= dispense_id_next;
      acc_coin_value <= acc_coin_next;
      coin_reject    <= coin_reject_next;
      sel_reject     <= sel_reject_next;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: scoreboard bench for vend_controller with a simple
// accumulator model closing the credit loop.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [4:0] coin_value = '0;
  logic       coin_reject;
  logic [4:0] acc_coin_value;
  logic       acc_clear;
  logic [4:0] current_amount;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = '0;
  logic       sel_reject;
  logic       cancel_req = 1'b0;
  logic       dispense_valid;
  logic [1:0] dispense_id;
  logic       dispense_ready = 1'b1;
  logic       change_valid;
  logic [4:0] change_coin;
  logic       change_ready = 1'b1;
  logic       busy;

  always #5 clk = ~clk;

  vend_controller #(
    .PRICE0(5), .PRICE1(8), .PRICE2(12), .PRICE3(15), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_value(coin_value), .coin_reject(coin_reject),
    .acc_coin_value(acc_coin_value), .acc_clear(acc_clear), .current_amount(current_amount),
    .sel_valid(sel_valid), .sel_id(sel_id), .sel_reject(sel_reject),
    .cancel_req(cancel_req),
    .dispense_valid(dispense_valid), .dispense_id(dispense_id), .dispense_ready(dispense_ready),
    .change_valid(change_valid), .change_coin(change_coin), .change_ready(change_ready),
    .busy(busy)
  );

  // Accumulator model.
  logic [4:0] acc;
  assign current_amount = acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         acc <= '0;
    else if (acc_clear) acc <= '0;
    else                acc <= acc + acc_coin_value;
  end

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [4:0]  exp_change[$];
  logic [1:0]  exp_disp[$];
  int unsigned coin_rej_seen = 0;
  int unsigned sel_rej_seen = 0;
  int unsigned clear_seen = 0;
  logic        chg_stalled = 1'b0;
  logic [4:0]  chg_held = '0;
  logic        disp_stalled = 1'b0;
  logic [1:0]  disp_held = '0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      chg_stalled  = 1'b0;
      disp_stalled = 1'b0;
    end else begin
      if (coin_reject) coin_rej_seen++;
      if (sel_reject)  sel_rej_seen++;
      if (acc_clear)   clear_seen++;
      if (change_valid && chg_stalled) check_eq("chg_stable", change_coin, chg_held);
      if (dispense_valid && disp_stalled) check_eq("disp_stable", dispense_id, disp_held);
      if (change_valid && change_ready) begin
        if (exp_change.size() == 0) check_eq("chg_unexpected", change_coin, 0);
        else                        check_eq("chg_coin", change_coin, exp_change.pop_front());
      end
      if (dispense_valid && dispense_ready) begin
        if (exp_disp.size() == 0) check_eq("disp_unexpected", 32'(dispense_id) + 1, 0);
        else                      check_eq("disp_id", dispense_id, exp_disp.pop_front());
      end
      chg_stalled  = change_valid && !change_ready;
      chg_held     = change_coin;
      disp_stalled = dispense_valid && !dispense_ready;
      disp_held    = dispense_id;
    end
  end

  function automatic int unsigned all_outputs();
    return {coin_reject, acc_coin_value, acc_clear, sel_reject, dispense_valid,
            dispense_id, change_valid, change_coin, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [4:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
    coin_value = '0;
  endtask

  task automatic select(input logic [1:0] id);
    sel_valid = 1'b1;
    sel_id    = id;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit, input bit jitter);
    int unsigned n = 0;
    while (busy && n < limit) begin
      if (jitter) change_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    change_ready = 1'b1;
    check_eq("done_in_time", busy, 0);
    tick();
  endtask

  task automatic scen_end(input string name, input int unsigned crej,
                          input int unsigned srej, input int unsigned clr);
    check_eq({name, "_coin_rej"}, coin_rej_seen, crej);
    check_eq({name, "_sel_rej"}, sel_rej_seen, srej);
    check_eq({name, "_clear"}, clear_seen, clr);
    check_eq({name, "_chg_left"}, exp_change.size(), 0);
    check_eq({name, "_disp_left"}, exp_disp.size(), 0);
    exp_change.delete();
    exp_disp.delete();
    coin_rej_seen = 0;
    sel_rej_seen  = 0;
    clear_seen    = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check_eq("reset_outputs", all_outputs(), 0);
    rst_n = 1'b1;
    tick();

    // 10 in, product 1 (8): change 1,1.
    exp_disp.push_back(2'd1);
    exp_change.push_back(5'd1); exp_change.push_back(5'd1);
    coin(5'd10);
    select(2'd1);
    check_eq("sel_to_dispense", dispense_valid, 1);
    wait_done(50, 1'b0);
    scen_end("s1", 0, 0, 1);

    // 5 in, product 2 refused; add 10, reselect: change 1,1,1.
    coin(5'd5);
    select(2'd2);
    check_eq("sel_reject_pulse", sel_reject, 1);
    tick();
    exp_disp.push_back(2'd2);
    repeat (3) exp_change.push_back(5'd1);
    coin(5'd10);
    select(2'd2);
    wait_done(50, 1'b1);
    scen_end("s2", 0, 1, 1);

    // Illegal coin, then overflowing coin; credit 30 refunded by cancel.
    coin(5'd3);
    check_eq("coin_reject_pulse", coin_reject, 1);
    coin(5'd10); coin(5'd10); coin(5'd10); coin(5'd5);
    check_eq("overflow_acc_zero", acc_coin_value, 0);
    tick();
    repeat (3) exp_change.push_back(5'd10);
    cancel_req = 1'b1;
    tick();
    cancel_req = 1'b0;
    wait_done(50, 1'b0);
    scen_end("s3", 2, 0, 1);

    // Credit 16, cancel + select + coin together: refund wins, coin refused.
    coin(5'd10); coin(5'd5); coin(5'd1);
    exp_change.push_back(5'd10); exp_change.push_back(5'd5); exp_change.push_back(5'd1);
    cancel_req = 1'b1; sel_valid = 1'b1; sel_id = 2'd0;
    coin_valid = 1'b1; coin_value = 5'd1;
    tick();
    cancel_req = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; coin_value = '0;
    wait_done(50, 1'b0);
    scen_end("s4", 1, 0, 1);

    // Credit 15, product 3, dispenser stalls for 5 cycles.
    coin(5'd10); coin(5'd5);
    dispense_ready = 1'b0;
    exp_disp.push_back(2'd3);
    select(2'd3);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid", dispense_valid, 1);
      check_eq("stall_id", dispense_id, 3);
      check_eq("stall_no_change", change_valid, 0);
      check_eq("stall_no_clear", acc_clear, 0);
      tick();
    end
    dispense_ready = 1'b1;
    wait_done(50, 1'b0);
    scen_end("s5", 0, 0, 1);

    // Credit 31 at the ceiling, product 3: change 10,5,1.
    coin(5'd10); coin(5'd10); coin(5'd10); coin(5'd1);
    exp_disp.push_back(2'd3);
    exp_change.push_back(5'd10); exp_change.push_back(5'd5); exp_change.push_back(5'd1);
    select(2'd3);
    wait_done(80, 1'b1);
    scen_end("s6", 0, 0, 1);

    // Coin latency, then reset mid-COLLECT returns to IDLE with no credit.
    coin(5'd5);
    check_eq("coin_latency", acc_coin_value, 5);
    tick();
    check_eq("coin_one_cycle", acc_coin_value, 0);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_outputs", all_outputs(), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    select(2'd0);
    tick();
    scen_end("s7", 0, 1, 0);

`ifdef VM_AUTO_REFUND_EN
    // Idle credit of 6 times out and refunds 5,1.
    coin(5'd5); coin(5'd1);
    exp_change.push_back(5'd5); exp_change.push_back(5'd1);
    for (int n = 0; n < 60 && !busy; n++) tick();
    check_eq("timeout_fired", busy, 1);
    wait_done(50, 1'b0);
    scen_end("s8", 0, 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
